// File: rtl/instr_encoder_if.sv
// Handshake bundle between a control-bundle producer, the instruction encoder
// and the serial sink.
interface instr_encoder_if #(
  parameter int OPERAND_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 bez;
  logic                 ja;
  logic                 op1;
  logic                 op2;
  logic                 writeReg;
  logic                 writex8;
  logic [1:0]           x8Sel;
  logic [OPERAND_W-1:0] operand;
  logic                 ser_data;
  logic                 ser_valid;
  logic                 ser_ready;
  logic                 ser_last;
  logic                 err;
  logic [7:0]           word_count;

  modport master (
    output in_valid, bez, ja, op1, op2, writeReg, writex8, x8Sel, operand, ser_ready,
    input  in_ready, ser_data, ser_valid, ser_last, err, word_count
  );

  modport slave (
    input  in_valid, bez, ja, op1, op2, writeReg, writex8, x8Sel, operand, ser_ready,
    output in_ready, ser_data, ser_valid, ser_last, err, word_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes a control-signal bundle into {opcode, operand} and streams it out
// serially, MSB first, over a valid/ready bit interface.
//
// state | meaning
// IDLE  | waiting for a bundle, in_ready high
// SHIFT | presenting word bits, one per ser_valid&&ser_ready
// ERR   | one-cycle err pulse after an illegal bundle
module instr_encoder #(
  parameter int OPERAND_W = 5
) (
  input logic         clk,
  input logic         reset,
  instr_encoder_if.slave bus
);
  localparam int W     = OPERAND_W + 3;
  localparam int CNT_W = $clog2(W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ERR   = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     word;
  logic [CNT_W-1:0] bits_left;
  logic [7:0]       words_done;
  logic [7:0]       bundle;
  logic [2:0]       opcode;
  logic             legal;

  // Bundle order: bez, ja, op1, op2, writeReg, writex8, x8Sel[1:0]
  always_comb begin
    bundle = {bus.bez, bus.ja, bus.op1, bus.op2, bus.writeReg, bus.writex8, bus.x8Sel};
    legal  = 1'b1;
    opcode = 3'b111;
    case (bundle)
      8'b0000_0101: opcode = 3'b000;
      8'b0010_0110: opcode = 3'b001;
      8'b1001_0000: opcode = 3'b010;
      8'b0000_0100: opcode = 3'b011;
      8'b0000_1000: opcode = 3'b100;
      8'b0111_0000: opcode = 3'b101;
      8'b0010_0111: opcode = 3'b110;
      8'b0000_0000: opcode = 3'b111;
      default:      legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      bits_left  <= '0;
      words_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (legal) begin
              state     <= SHIFT;
              word      <= {opcode, bus.operand};
              bits_left <= CNT_W'(W - 1);
            end else begin
              state <= ERR;
            end
          end
        end
        SHIFT: begin
          // ser_valid is implied by SHIFT, so ser_ready alone completes the handshake
          if (bus.ser_ready) begin
            if (bits_left == '0) begin
              state      <= IDLE;
              words_done <= words_done + 8'd1;
            end else begin
              word      <= {word[W-2:0], 1'b0};
              bits_left <= bits_left - 1'b1;
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.ser_valid  = (state == SHIFT);
  assign bus.ser_last   = (state == SHIFT) && (bits_left == '0);
  assign bus.err        = (state == ERR);
  assign bus.ser_data   = word[W-1];
  assign bus.word_count = words_done;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued at acceptance
// and compared as the serial stream completes each word.
module tb_instr_encoder;
  localparam int OPERAND_W = 5;
  localparam int W = OPERAND_W + 3;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic rdy_mode = 1'b0;
  logic [7:0] exp_wc = '0;
  logic [W-1:0] sb[$];

  // legal bundles in opcode order 000..111
  logic [7:0] legal_b [8] = '{8'h05, 8'h26, 8'h90, 8'h04, 8'h08, 8'h70, 8'h27, 8'h00};

  instr_encoder_if #(.OPERAND_W(OPERAND_W)) bus ();

  instr_encoder #(.OPERAND_W(OPERAND_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [7:0] b);
    {bus.bez, bus.ja, bus.op1, bus.op2, bus.writeReg, bus.writex8, bus.x8Sel} = b;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] b, input logic [OPERAND_W-1:0] opnd,
                      input logic ok, input logic [2:0] opc);
    wait_idle();
    set_bundle(b);
    bus.operand  = opnd;
    bus.in_valid = 1'b1;
    if (ok) sb.push_back({opc, opnd});
    tick();
    // scramble inputs: the accepted word must already be latched
    bus.in_valid = 1'b0;
    set_bundle(8'($urandom));
    bus.operand = OPERAND_W'($urandom);
    if (ok) begin
      chk("first_valid", bus.ser_valid, 1);
      chk("first_msb", bus.ser_data, opc[2]);
      chk("first_err", bus.err, 0);
    end else begin
      chk("err_pulse", bus.err, 1);
      chk("err_no_valid", bus.ser_valid, 0);
      tick();
      chk("err_clear", bus.err, 0);
      chk("err_ready", bus.in_ready, 1);
      chk("err_no_valid2", bus.ser_valid, 0);
    end
  endtask

  // ser_ready driver: steady 1, or the 1,0,0 stall pattern
  initial begin
    int ph = 0;
    bus.ser_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ser_ready = rdy_mode ? (ph == 0) : 1'b1;
      ph = (ph + 1) % 3;
    end
  end

  // Serial monitor and scoreboard
  logic [W-1:0] acc = '0;
  int           nbits = 0;
  logic         stalled = 1'b0;
  logic         hold_d, hold_l;
  always @(negedge clk) begin
    if (reset) begin
      acc     = '0;
      nbits   = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", bus.ser_valid, 1);
        chk("stall_data", bus.ser_data, hold_d);
        chk("stall_last", bus.ser_last, hold_l);
      end
      stalled = bus.ser_valid && !bus.ser_ready;
      hold_d  = bus.ser_data;
      hold_l  = bus.ser_last;
      if (bus.ser_valid && bus.ser_ready) begin
        chk("ser_last_pos", bus.ser_last, (nbits == W - 1));
        acc = {acc[W-2:0], bus.ser_data};
        nbits++;
        if (bus.ser_last) begin
          if (sb.size() == 0) chk("sb_unexpected_word", 0, 1);
          else chk("word", acc, sb.pop_front());
          exp_wc = exp_wc + 8'd1;
          acc    = '0;
          nbits  = 0;
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    set_bundle(8'h00);
    bus.operand  = '0;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ser_valid", bus.ser_valid, 0);
    chk("rst_ser_data", bus.ser_data, 0);
    chk("rst_ser_last", bus.ser_last, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_word_count", bus.word_count, 0);
    reset = 1'b0;
    tick();

    // add, operand 0x0A, with exact word timing
    send(8'h26, 5'h0A, 1'b1, 3'b001);
    for (int i = 1; i < W; i++) begin
      chk("add_busy", bus.in_ready, 0);
      tick();
    end
    chk("add_last", bus.ser_last, 1);
    tick();
    chk("add_done_ready", bus.in_ready, 1);
    chk("add_word_count", bus.word_count, 1);

    // every opcode, operand 0
    for (int i = 0; i < 8; i++) send(legal_b[i], '0, 1'b1, 3'(i));
    wait_idle();
    chk("all_ops_wc", bus.word_count, 9);

    // illegal bundles
    send(8'hC0, 5'h03, 1'b0, 3'b000);
    send(8'h06, 5'h1F, 1'b0, 3'b000);
    chk("illegal_wc", bus.word_count, 9);

    // li 0x1F under ser_ready stalls
    rdy_mode = 1'b1;
    send(8'h05, 5'h1F, 1'b1, 3'b000);
    wait_idle();
    rdy_mode = 1'b0;
    tick();
    chk("stall_wc", bus.word_count, 10);

    // reset after three bits of sr
    send(8'h08, 5'h15, 1'b1, 3'b100);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("abort_valid", bus.ser_valid, 0);
    chk("abort_wc", bus.word_count, 0);
    reset = 1'b0;
    sb.delete();
    exp_wc = '0;
    repeat (3) tick();
    chk("abort_no_resume", bus.ser_valid, 0);
    send(8'h70, 5'h11, 1'b1, 3'b101);
    wait_idle();
    chk("ja_after_abort_wc", bus.word_count, 1);

    // 256 words wrap the counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    exp_wc = '0;
    tick();
    for (int n = 0; n < 256; n++) begin
      int k;
      k = int'($urandom_range(0, 7));
      send(legal_b[k], OPERAND_W'($urandom), 1'b1, 3'(k));
      wait_idle();
      if (n == 254) chk("wc_255", bus.word_count, 255);
    end
    tick();
    chk("wc_wrap", bus.word_count, 0);
    chk("wc_model", bus.word_count, exp_wc);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
